// File: rtl/mem_access_ctrl_if.sv
// Bus bundle that joins the CPU load/store port, mem_access_ctrl and the data memory.
// The master modport is the controller's view of the bundle. The slave modport is the
// view of the environment around it: the CPU driving requests and the memory answering.
interface mem_access_ctrl_if;
    logic [3:0]  cpu_read;
    logic [2:0]  cpu_write;
    logic [31:0] cpu_address;
    logic [31:0] cpu_writedata;
    logic [31:0] cpu_readdata;
    logic        stall;
    logic [1:0]  fault;
    logic [3:0]  mem_read;
    logic [2:0]  mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    modport master (
        input  cpu_read, cpu_write, cpu_address, cpu_writedata, mem_readdata, mem_busywait,
        output cpu_readdata, stall, fault, mem_read, mem_write, mem_address, mem_writedata
    );

    modport slave (
        output cpu_read, cpu_write, cpu_address, cpu_writedata, mem_readdata, mem_busywait,
        input  cpu_readdata, stall, fault, mem_read, mem_write, mem_address, mem_writedata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store controller that sits between a CPU pipeline and a data memory with busywait.
// It checks requests for alignment and read/write conflicts, places store lanes, waits
// on the memory with a timeout, and sign- or zero-extends load results.
//
// Handshake: the CPU offers a request by setting exactly one enable while the controller
// is in IDLE. The request is accepted in that same cycle, and stall then stays high
// (not ready) until the DONE cycle. On the memory side, a non-zero mem_read or mem_write
// means valid and mem_busywait=1 means not ready. The transfer completes in the first
// WAIT cycle that sees mem_busywait=0. Any cpu_* value presented outside IDLE is ignored.
module mem_access_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    mem_access_ctrl_if.master bus,
    output logic [1:0]        dbg_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT    = 8'(TIMEOUT);
    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_CONFLICT = 2'b10;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

    state_t      state;
    state_t      state_next;

    // Decoded view of the request currently on the cpu_* inputs.
    logic        req_rd;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        misaligned;
    logic        legal;
    logic [1:0]  req_fault;
    logic [31:0] req_wdata;

    // Request latched on acceptance.
    logic        is_load;
    logic [2:0]  funct_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [7:0]  wait_cnt;

    logic        timed_out;
    logic        mem_drive;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_value;

    // Decode the request: size, alignment, conflict, and store lane placement.
    always_comb begin
        req_rd   = bus.cpu_read[3];
        req_wr   = bus.cpu_write[2];
        req_size = req_rd ? bus.cpu_read[1:0] : bus.cpu_write[1:0];
        misaligned = 1'b0;
        if (req_size == 2'b01) begin
            misaligned = bus.cpu_address[0];
        end else if (req_size[1]) begin
            misaligned = (bus.cpu_address[1:0] != 2'b00);
        end
        legal = (req_rd ^ req_wr) && !misaligned;
        req_fault = FAULT_NONE;
        if (req_rd && req_wr) begin
            req_fault = FAULT_CONFLICT;
        end else if ((req_rd || req_wr) && misaligned) begin
            req_fault = FAULT_MISALIGN;
        end
        case (bus.cpu_write[1:0])
            2'b00:   req_wdata = {4{bus.cpu_writedata[7:0]}};
            2'b01:   req_wdata = {2{bus.cpu_writedata[15:0]}};
            default: req_wdata = bus.cpu_writedata;
        endcase
    end

    // Select the addressed lane of the returned word and extend it per the load code.
    always_comb begin
        case (addr_q[1:0])
            2'b00:   byte_lane = bus.mem_readdata[7:0];
            2'b01:   byte_lane = bus.mem_readdata[15:8];
            2'b10:   byte_lane = bus.mem_readdata[23:16];
            default: byte_lane = bus.mem_readdata[31:24];
        endcase
        half_lane = addr_q[1] ? bus.mem_readdata[31:16] : bus.mem_readdata[15:0];
        case (funct_q)
            3'b000:  load_value = {{24{byte_lane[7]}}, byte_lane};
            3'b001:  load_value = {{16{half_lane[15]}}, half_lane};
            3'b100:  load_value = {24'd0, byte_lane};
            3'b101:  load_value = {16'd0, half_lane};
            default: load_value = bus.mem_readdata;
        endcase
    end

    assign timed_out = (state == WAIT) && bus.mem_busywait && (wait_cnt == TIMEOUT_CNT);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (legal) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT: begin
                if (!bus.mem_busywait) begin
                    state_next = DONE;
                end else if (timed_out) begin
                    state_next = IDLE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic. Reset gates the combinational outputs so they read zero at once.
    always_comb begin
        bus.stall     = 1'b0;
        bus.fault     = FAULT_NONE;
        bus.mem_read  = 4'b0000;
        bus.mem_write = 3'b000;
        mem_drive     = 1'b0;
        case (state)
            IDLE: begin
                bus.stall = legal;
                bus.fault = req_fault;
            end
            ISSUE: begin
                bus.stall = 1'b1;
                mem_drive = 1'b1;
            end
            WAIT: begin
                bus.stall = !timed_out;
                bus.fault = timed_out ? FAULT_TIMEOUT : FAULT_NONE;
                mem_drive = bus.mem_busywait && !timed_out;
            end
            default: ;
        endcase
        if (mem_drive) begin
            bus.mem_read  = is_load ? {1'b1, funct_q} : 4'b0000;
            bus.mem_write = is_load ? 3'b000 : {1'b1, funct_q[1:0]};
        end
        if (!reset) begin
            bus.stall     = 1'b0;
            bus.fault     = FAULT_NONE;
            bus.mem_read  = 4'b0000;
            bus.mem_write = 3'b000;
        end
    end

    // Request latch, wait counter and load result register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            is_load  <= 1'b0;
            funct_q  <= 3'b000;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            wait_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (legal) begin
                        addr_q  <= bus.cpu_address;
                        is_load <= req_rd;
                        funct_q <= req_rd ? bus.cpu_read[2:0] : {1'b0, bus.cpu_write[1:0]};
                        if (req_wr) begin
                            wdata_q <= req_wdata;
                        end
                    end
                end
                ISSUE: wait_cnt <= 8'd0;
                WAIT: begin
                    if (bus.mem_busywait) begin
                        if (wait_cnt != 8'hFF) begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                    end else if (is_load) begin
                        rdata_q <= load_value;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_address   = addr_q;
    assign bus.mem_writedata = wdata_q;
    assign bus.cpu_readdata  = rdata_q;
    assign dbg_state         = state;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed and random loads/stores against a
// transaction-level model of the expected cycle timeline and data.
module tb_mem_access_ctrl;
  localparam int TIMEOUT = 255;

  logic       clock;
  logic       reset;
  logic [1:0] dbg_state;
  int         n_checks;
  int         n_errors;
  logic [31:0] exp_q[$];
  logic [31:0] last_load;

  mem_access_ctrl_if bus_if ();

  mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus_if),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    logic [31:0] b;
    logic [31:0] h;
    b = (word >> (8 * (addr % 4))) % 256;
    h = (word >> (16 * ((addr % 4) / 2))) % 65536;
    case (f3)
      3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] model_place(input logic [1:0] f2, input logic [31:0] w);
    case (f2)
      2'b00:   return (w % 256) * 32'h0101_0101;
      2'b01:   return (w % 65536) * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  // driver tasks
  task automatic drive_idle();
    bus_if.cpu_read      = 4'b0000;
    bus_if.cpu_write     = 3'b000;
    bus_if.cpu_address   = 32'd0;
    bus_if.cpu_writedata = 32'd0;
  endtask

  task automatic drive_garbage();
    bus_if.cpu_read      = 4'($urandom_range(0, 15));
    bus_if.cpu_write     = 3'($urandom_range(0, 7));
    bus_if.cpu_address   = $urandom;
    bus_if.cpu_writedata = $urandom;
  endtask

  // Entered and left just after a rising edge. Cycle 0 presents the request; the memory
  // holds busywait high for `busy` WAIT cycles.
  task automatic run_access(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata, input int busy);
    bit is_rd, is_wr, misal, legal, tmo, exp_act;
    int size_bytes, exp_stall_n, exp_act_n, exp_fault_cyc, done_cyc, n_cycles;
    int stall_err, act_err, bus_err, fault_err;
    logic [1:0]  exp_fault, exp_f;
    logic [3:0]  exp_mr;
    logic [2:0]  exp_mw;
    logic [31:0] exp_wd, exp_val;
    is_rd = rd[3];
    is_wr = wr[2];
    size_bytes = 1 << (is_rd ? int'(rd[1:0]) : int'(wr[1:0]));
    misal = (is_rd ^ is_wr) && ((addr % size_bytes) != 0);
    legal = (is_rd ^ is_wr) && !misal;
    tmo = legal && (busy > TIMEOUT);
    exp_fault_cyc = -1;
    exp_fault = 2'b00;
    if (is_rd && is_wr) begin
      exp_fault = 2'b10; exp_fault_cyc = 0;
    end else if (misal) begin
      exp_fault = 2'b01; exp_fault_cyc = 0;
    end else if (tmo) begin
      exp_fault = 2'b11; exp_fault_cyc = TIMEOUT + 2;
    end
    exp_stall_n = !legal ? 0 : (tmo ? TIMEOUT + 2 : busy + 3);
    exp_act_n   = !legal ? 0 : (tmo ? TIMEOUT + 1 : busy + 1);
    done_cyc    = !legal ? 0 : (tmo ? TIMEOUT + 2 : busy + 3);
    n_cycles    = done_cyc + 2;
    exp_mr = is_rd ? rd : 4'b0000;
    exp_mw = is_wr ? wr : 3'b000;
    exp_wd = model_place(wr[1:0], wdata);
    if (legal && is_rd && !tmo) exp_q.push_back(model_load(rd[2:0], addr, rdata));
    stall_err = 0; act_err = 0; bus_err = 0; fault_err = 0;
    for (int cyc = 0; cyc < n_cycles; cyc++) begin
      if (cyc == 0) begin
        bus_if.cpu_read      = rd;
        bus_if.cpu_write     = wr;
        bus_if.cpu_address   = addr;
        bus_if.cpu_writedata = wdata;
      end else if (cyc <= done_cyc) begin
        drive_garbage();
      end else begin
        drive_idle();
      end
      bus_if.mem_busywait = legal && (cyc >= 1) && (cyc <= busy + 1);
      bus_if.mem_readdata = (legal && !tmo && cyc == busy + 2) ? rdata : $urandom;
      @(negedge clock);
      if (bus_if.stall !== (cyc < exp_stall_n)) stall_err++;
      exp_act = (cyc >= 1) && (cyc <= exp_act_n);
      if (((bus_if.mem_read != 4'b0000) || (bus_if.mem_write != 3'b000)) !== exp_act) act_err++;
      if (exp_act && ((bus_if.mem_read !== exp_mr) || (bus_if.mem_write !== exp_mw) ||
                      (bus_if.mem_address !== addr) || (is_wr && bus_if.mem_writedata !== exp_wd)))
        bus_err++;
      exp_f = (cyc == exp_fault_cyc) ? exp_fault : 2'b00;
      if (bus_if.fault !== exp_f) fault_err++;
      if (legal && is_rd && !tmo && cyc == done_cyc) begin
        exp_val = exp_q.pop_front();
        check("load_data", bus_if.cpu_readdata, exp_val);
        last_load = exp_val;
      end
      if (cyc == n_cycles - 1) check("readdata_hold", bus_if.cpu_readdata, last_load);
      @(posedge clock);
      #1;
    end
    check("stall_timeline", stall_err, 0);
    check("mem_active_timeline", act_err, 0);
    check("mem_bus_values", bus_err, 0);
    check("fault_timeline", fault_err, 0);
  endtask

  // Start a load, pull reset low in the middle of WAIT, and confirm the access is dropped.
  task automatic reset_mid_wait();
    int idle_err;
    bus_if.cpu_read = 4'b1010;
    bus_if.cpu_write = 3'b000;
    bus_if.cpu_address = 32'h0000_0010;
    bus_if.mem_busywait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      drive_garbage();
    end
    reset = 1'b0;
    #1;
    check("rst_stall", bus_if.stall, 0);
    check("rst_fault", bus_if.fault, 0);
    check("rst_mem_read", bus_if.mem_read, 0);
    check("rst_mem_write", bus_if.mem_write, 0);
    check("rst_mem_address", bus_if.mem_address, 0);
    check("rst_mem_writedata", bus_if.mem_writedata, 0);
    check("rst_cpu_readdata", bus_if.cpu_readdata, 0);
    last_load = 32'd0;
    @(posedge clock);
    #1;
    drive_idle();
    bus_if.mem_busywait = 1'b0;
    reset = 1'b1;
    idle_err = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (bus_if.stall !== 1'b0 || bus_if.fault !== 2'b00 || bus_if.mem_read !== 4'b0000 ||
          bus_if.mem_write !== 3'b000 || bus_if.cpu_readdata !== 32'd0)
        idle_err++;
      @(posedge clock);
      #1;
    end
    check("abandoned_access_silent", idle_err, 0);
  endtask

  // main sequence
  initial begin
    n_checks = 0;
    n_errors = 0;
    last_load = 32'd0;
    reset = 1'b0;
    bus_if.cpu_read = 4'b1010;
    bus_if.cpu_write = 3'b000;
    bus_if.cpu_address = 32'h0000_0000;
    bus_if.cpu_writedata = 32'd0;
    bus_if.mem_busywait = 1'b0;
    bus_if.mem_readdata = 32'hDEAD_BEEF;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_stall", bus_if.stall, 0);
    check("reset_fault", bus_if.fault, 0);
    check("reset_mem_read", bus_if.mem_read, 0);
    check("reset_mem_write", bus_if.mem_write, 0);
    check("reset_mem_address", bus_if.mem_address, 0);
    check("reset_cpu_readdata", bus_if.cpu_readdata, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // SW accepted on the first edge after reset release
    run_access(4'b0000, 3'b110, 32'h0000_0004, 32'hAABB_CCDD, 32'd0, 2);
    run_access(4'b1000, 3'b000, 32'h0000_0005, 32'd0, 32'hAABB_CCDD, 0);
    check("lb_0x05", last_load, 32'hFFFF_FFCC);
    run_access(4'b1100, 3'b000, 32'h0000_0005, 32'd0, 32'hAABB_CCDD, 1);
    check("lbu_0x05", last_load, 32'h0000_00CC);
    run_access(4'b1001, 3'b000, 32'h0000_0003, 32'd0, 32'hAABB_CCDD, 0);
    run_access(4'b1010, 3'b110, 32'h0000_0008, 32'h1234_5678, 32'hAABB_CCDD, 0);
    run_access(4'b0000, 3'b100, 32'h0000_0013, 32'h0000_00A5, 32'd0, 0);
    run_access(4'b0000, 3'b101, 32'h0000_0012, 32'h0000_BEEF, 32'd0, 3);
    run_access(4'b1101, 3'b000, 32'h0000_0022, 32'd0, 32'h8001_7FFF, 0);
    run_access(4'b1010, 3'b000, 32'h0000_0040, 32'd0, 32'h0BAD_F00D, TIMEOUT);
    run_access(4'b1010, 3'b000, 32'h0000_0044, 32'd0, 32'h0BAD_F00D, TIMEOUT + 1);
    run_access(4'b1001, 3'b000, 32'h0000_0046, 32'd0, 32'h9876_5432, 0);

    reset_mid_wait();
    run_access(4'b1010, 3'b000, 32'h0000_0008, 32'd0, 32'h1122_3344, 0);
    check("lw_after_reset", last_load, 32'h1122_3344);

    for (int t = 0; t < 40; t++) begin
      logic [3:0] rd;
      logic [2:0] wr;
      logic [31:0] a;
      int kind, sz;
      logic [2:0] load_codes[5];
      load_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      kind = $urandom_range(0, 9);
      rd = 4'b0000;
      wr = 3'b000;
      if (kind == 0) begin
        rd = {1'b1, load_codes[$urandom_range(0, 4)]};
        wr = {1'b1, 2'($urandom_range(0, 2))};
      end else if (kind <= 5) begin
        rd = {1'b1, load_codes[$urandom_range(0, 4)]};
      end else begin
        wr = {1'b1, 2'($urandom_range(0, 2))};
      end
      sz = 1 << (rd[3] ? int'(rd[1:0]) : int'(wr[1:0]));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a - (a % sz);
      run_access(rd, wr, a, $urandom, $urandom, $urandom_range(0, 6));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
